// File: rtl/dmem_responder.sv
// Handshaked data-memory responder for the CPU load/store port.
// Takes one RV32I load/store at a time, performs the byte/half/word access
// at the accept edge, then presents the result after WAIT_CYCLES wait states
// and holds it until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The request side must hold req_* stable while req_valid && !req_ready.
// The response side (resp_valid/resp_rdata/resp_err) stays stable until the
// edge where resp_valid && resp_ready. req_ready depends only on registered
// state and reset, never on req_valid.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter     MEMFILE     = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          f3_legal;
  logic          misalign;
  logic          out_of_range;
  logic          req_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_data;
  logic [3:0]    st_be;
  logic [31:0]   st_data;

  assign accept = req_valid && req_ready;

  // Request decode: legality, alignment, range and word/lane selection.
  always_comb begin
    lane         = req_addr[1:0];
    word_idx     = req_addr[AW+1:2];
    out_of_range = |req_addr[31:AW+2];
    if (req_we) begin
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    misalign = ((req_funct3[1:0] == 2'b01) && lane[0]) ||
               ((req_funct3[1:0] == 2'b10) && (lane != 2'b00));
    req_err  = !f3_legal || misalign || out_of_range;
  end

  // Load path: pick the addressed byte/half and extend according to funct3.
  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  // Store path: replicate the LSB-aligned data across lanes, enable only the addressed ones.
  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  // Array write: commit enabled byte lanes of a legal store at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CW'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CW'(1)) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    req_ready  = (state == S_IDLE) && !reset;
    resp_valid = (state == S_RESP);
    dbg_state  = state;
  end

  // Response payload captured at accept and held through WAIT/RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_err   <= req_err;
      resp_rdata <= (!req_we && !req_err) ? ld_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan steps, reset cases, a
// zero-wait-state instance, and a randomized phase against a byte-level model.
module tb_dmem_responder;

  localparam int MAIN_DEPTH = 1024;
  localparam int MAIN_WAIT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance (WAIT_CYCLES = 2)
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  // zero-wait instance
  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [2:0]  z_req_funct3;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_resp_rdata;
  logic [1:0]  z_dbg_state;

  dmem_responder #(.DEPTH_WORDS(MAIN_DEPTH), .WAIT_CYCLES(MAIN_WAIT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_zdut (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_funct3(z_req_funct3), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] ref_mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference: legality, alignment, range, then byte moves.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int nbytes;
    logic legal;
    logic [31:0] val;
    nbytes = 1 << f3[1:0];
    legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err    = !legal || ((addr % nbytes) != 0) || (addr >= MAIN_DEPTH * 4);
    rd     = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wd[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[addr + i]) << (8 * i));
        if (!f3[2] && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
        rd = val;
      end
    end
  endfunction

  // ---------------- driver ----------------
  // One full transaction on the main instance; hold = cycles of response backpressure.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd_o, output logic err_o);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        seen;
    int          n;
    model(we, addr, f3, wd, exp_rd, exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = resp_valid;
    end
    check("latency", 32'(n), 32'(MAIN_WAIT + 1));
    rd_o = resp_rdata; err_o = resp_err;
    check("rdata_model", resp_rdata, exp_rd);
    check("err_model", 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", 32'(resp_err), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(resp_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        saw_valid;

    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_funct3 = 0; req_wdata = 0; resp_ready = 0;
    z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_funct3 = 0; z_req_wdata = 0;
    z_resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);

    // word round trip
    txn(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 0, rd, er);
    check("sw_rdata_zero", rd, 32'd0);
    txn(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
    check("lw_roundtrip", rd, 32'hDEAD_BEEF);
    check("lw_roundtrip_err", 32'(er), 32'd0);

    // byte/half extension
    txn(1'b1, 32'h20, 3'b010, 32'h0, 0, rd, er);
    txn(1'b1, 32'h23, 3'b000, 32'h1234_5680, 0, rd, er);
    txn(1'b0, 32'h23, 3'b000, 32'h0, 0, rd, er);
    check("lb_sext", rd, 32'hFFFF_FF80);
    txn(1'b0, 32'h23, 3'b100, 32'h0, 0, rd, er);
    check("lbu_zext", rd, 32'h0000_0080);
    txn(1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er);
    check("lw_after_sb", rd, 32'h8000_0000);
    txn(1'b0, 32'h22, 3'b001, 32'h0, 0, rd, er);
    check("lh_sext", rd, 32'hFFFF_8000);
    txn(1'b0, 32'h22, 3'b101, 32'h0, 0, rd, er);
    check("lhu_zext", rd, 32'h0000_8000);

    // error cases
    txn(1'b0, 32'h12, 3'b010, 32'h0, 0, rd, er);
    check("lw_misalign_err", 32'(er), 32'd1);
    check("lw_misalign_rdata", rd, 32'd0);
    txn(1'b1, 32'h21, 3'b001, 32'hFFFF_FFFF, 0, rd, er);
    check("sh_misalign_err", 32'(er), 32'd1);
    txn(1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er);
    check("lw_unchanged", rd, 32'h8000_0000);
    txn(1'b0, 32'h0000_1000, 3'b010, 32'h0, 0, rd, er);
    check("lw_range_err", 32'(er), 32'd1);
    txn(1'b0, 32'h10, 3'b011, 32'h0, 0, rd, er);
    check("ld_f3_011_err", 32'(er), 32'd1);
    txn(1'b1, 32'h10, 3'b100, 32'h0, 0, rd, er);
    check("st_f3_100_err", 32'(er), 32'd1);

    // backpressure: 4 cycles with resp_ready low
    txn(1'b0, 32'h10, 3'b010, 32'h0, 4, rd, er);
    check("lw_backpressure", rd, 32'hDEAD_BEEF);

    // reset during WAIT abandons the response but keeps the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_funct3 = 3'b010; req_wdata = 32'h1122_3344;
    check("rstw_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(1'b1, 32'h40, 3'b010, 32'h1122_3344, exp_rd, exp_err);
    @(negedge clk);
    check("rstw_in_wait", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstw_ready_after", 32'(req_ready), 32'd1);
    saw_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_valid = saw_valid | resp_valid;
    end
    check("rstw_no_resp", 32'(saw_valid), 32'd0);
    txn(1'b0, 32'h40, 3'b010, 32'h0, 0, rd, er);
    check("rstw_store_kept", rd, 32'h1122_3344);

    // zero wait states: response one cycle after accept, next accept two cycles after
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h8; z_req_funct3 = 3'b010;
    z_req_wdata = 32'hCAFE_F00D;
    check("z_ready_idle", 32'(z_req_ready), 32'd1);
    @(posedge clk);
    #1 z_req_we = 1'b0;
    @(negedge clk);
    check("z_sw_valid", 32'(z_resp_valid), 32'd1);
    check("z_sw_busy", 32'(z_req_ready), 32'd0);
    check("z_sw_err", 32'(z_resp_err), 32'd0);
    @(negedge clk);
    check("z_valid_drop", 32'(z_resp_valid), 32'd0);
    check("z_ready_again", 32'(z_req_ready), 32'd1);
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    @(negedge clk);
    check("z_lw_valid", 32'(z_resp_valid), 32'd1);
    check("z_lw_rdata", z_resp_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    check("z_lw_drop", 32'(z_resp_valid), 32'd0);

    // randomized phase over a fully initialised region
    for (int w = 0; w < 16; w++) begin
      txn(1'b1, 32'h100 + 32'(4 * w), 3'b010, $urandom, 0, rd, er);
    end
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      txn(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 2), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // bound on total run time
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
